nq_inst_decode: RTL and testbench

- Decode stage of the NanoQuarter 16-bit CPU. It sits between instruction fetch and execute.
- Accepts raw 16-bit instruction words over a valid/ready handshake and buffers them in a 2-entry skid queue.
- Emits decoded fields (op, funct, shamt, idata, register addresses, class flags) to the ALU/execute stage over a second valid/ready handshake.
- Flags illegal encodings and counts them.

---
 rtl/nq_pkg.sv | 82 ++++++++
 rtl/nq_skid_fifo.sv | 56 +++++
 rtl/nq_inst_decode.sv | 80 ++++++++
 tb/tb_nq_inst_decode.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nq_pkg.sv
// Shared definitions for the NanoQuarter decode stage: opcode classes, {op,funct} codes,
// the decoded-instruction record and the combinational decode function.
package nq_pkg;

  localparam logic [1:0] OP_R  = 2'b00;
  localparam logic [1:0] OP_I  = 2'b01;
  localparam logic [1:0] OP_BR = 2'b10;
  localparam logic [1:0] OP_J  = 2'b11;

  localparam logic [4:0] NAND = 5'b00_000;
  localparam logic [4:0] AND  = 5'b00_001;
  localparam logic [4:0] OR   = 5'b00_010;
  localparam logic [4:0] XOR  = 5'b00_011;
  localparam logic [4:0] ADD  = 5'b00_100;
  localparam logic [4:0] SUB  = 5'b00_101;
  localparam logic [4:0] SLT  = 5'b00_110;
  localparam logic [4:0] LUI  = 5'b01_000;
  localparam logic [4:0] ADDI = 5'b01_001;
  localparam logic [4:0] ANDI = 5'b01_010;
  localparam logic [4:0] ORI  = 5'b01_011;
  localparam logic [4:0] LW   = 5'b01_100;
  localparam logic [4:0] SW   = 5'b01_101;

  localparam int unsigned OP_MSB    = 15;
  localparam int unsigned R_RD_MSB  = 13;
  localparam int unsigned R_RS1_MSB = 10;
  localparam int unsigned R_RS2_MSB = 7;
  localparam int unsigned R_FN_MSB  = 4;
  localparam int unsigned R_SH_MSB  = 1;
  localparam int unsigned I_FN_MSB  = 13;
  localparam int unsigned I_RD_MSB  = 10;
  localparam int unsigned IMM_MSB   = 7;

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  funct;
    logic [1:0]  shamt;
    logic [7:0]  idata;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] pc;
    logic        is_mem;
    logic        is_ctrl;
    logic        illegal;
  } dec_t;

  function automatic dec_t decode_inst(input logic [15:0] inst, input logic [15:0] pc);
    dec_t       d;
    logic [4:0] code;
    d    = '0;
    d.op = inst[OP_MSB -: 2];
    d.pc = pc;
    case (d.op)
      OP_R: begin
        d.rd    = inst[R_RD_MSB -: 3];
        d.rs1   = inst[R_RS1_MSB -: 3];
        d.rs2   = inst[R_RS2_MSB -: 3];
        d.funct = inst[R_FN_MSB -: 3];
        d.shamt = inst[R_SH_MSB -: 2];
      end
      OP_I: begin
        d.funct = inst[I_FN_MSB -: 3];
        d.rd    = inst[I_RD_MSB -: 3];
        d.rs1   = inst[I_RD_MSB -: 3];
        d.idata = inst[IMM_MSB -: 8];
      end
      default: begin
        d.funct = inst[I_FN_MSB -: 3];
        d.rs1   = inst[I_RD_MSB -: 3];
        d.idata = inst[IMM_MSB -: 8];
      end
    endcase
    code      = {d.op, d.funct};
    d.is_mem  = (code == LW) || (code == SW);
    d.is_ctrl = d.op[1];
    // Control classes accept every funct; only the top R and I codes are undefined.
    d.illegal = (code == 5'b00_111) || (code == 5'b01_110) || (code == 5'b01_111);
    return d;
  endfunction

endpackage

// File: rtl/nq_skid_fifo.sv
// DEPTH-entry valid/ready queue of decoded instructions; head entry drives the outputs directly.
module nq_skid_fifo
  import nq_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic push_valid_i,
  output logic push_ready_o,
  input  dec_t push_data_i,
  output logic pop_valid_o,
  input  logic pop_ready_i,
  output dec_t pop_data_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  dec_t          mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          push, pop;

  assign push_ready_o = (count_q < CW'(DEPTH));
  assign pop_valid_o  = (count_q != '0);
  assign pop_data_o   = mem_q[rptr_q];
  assign push         = push_valid_i & push_ready_o & ~flush_i;
  assign pop          = pop_valid_o & pop_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= push_data_i;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/nq_inst_decode.sv
// NanoQuarter decode stage: decodes on enqueue into a skid queue and counts illegal dequeues.
module nq_inst_decode
  import nq_pkg::*;
#(
  parameter int unsigned IW    = 16,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IW-1:0]   in_inst,
  input  logic [15:0]     in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [1:0]      out_op,
  output logic [2:0]      out_funct,
  output logic [1:0]      out_shamt,
  output logic [7:0]      out_idata,
  output logic [2:0]      out_rd,
  output logic [2:0]      out_rs1,
  output logic [2:0]      out_rs2,
  output logic [15:0]     out_pc,
  output logic            out_is_mem,
  output logic            out_is_ctrl,
  output logic            out_illegal,
  output logic [CNTW-1:0] illegal_cnt
);

  dec_t            dec_in, head;
  logic [CNTW-1:0] cnt_q, cnt_d;

  assign dec_in = decode_inst(in_inst[15:0], in_pc);

  nq_skid_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .push_valid_i(in_valid),
    .push_ready_o(in_ready),
    .push_data_i (dec_in),
    .pop_valid_o (out_valid),
    .pop_ready_i (out_ready),
    .pop_data_o  (head)
  );

  assign out_op      = head.op;
  assign out_funct   = head.funct;
  assign out_shamt   = head.shamt;
  assign out_idata   = head.idata;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_pc      = head.pc;
  assign out_is_mem  = head.is_mem;
  assign out_is_ctrl = head.is_ctrl;
  assign out_illegal = head.illegal;
  assign illegal_cnt = cnt_q;

  // A dequeue in a flush cycle still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && head.illegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_nq_inst_decode.sv
// Self-checking bench for nq_inst_decode: decode vector table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_nq_inst_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_inst = '0;
  logic [15:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  out_op;
  logic [2:0]  out_funct;
  logic [1:0]  out_shamt;
  logic [7:0]  out_idata;
  logic [2:0]  out_rd, out_rs1, out_rs2;
  logic [15:0] out_pc;
  logic        out_is_mem, out_is_ctrl, out_illegal;
  logic [7:0]  illegal_cnt;

  always #5 clk = ~clk;

  nq_inst_decode #(
    .IW   (16),
    .DEPTH(2),
    .CNTW (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_funct  (out_funct),
    .out_shamt  (out_shamt),
    .out_idata  (out_idata),
    .out_rd     (out_rd),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_pc     (out_pc),
    .out_is_mem (out_is_mem),
    .out_is_ctrl(out_is_ctrl),
    .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  typedef struct packed {
    logic [15:0] inst;
    logic [1:0]  op;
    logic [2:0]  funct;
    logic [1:0]  shamt;
    logic [7:0]  idata;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        mem;
    logic        ctrl;
    logic        ill;
  } vec_t;

  vec_t        tbl [10];
  logic [42:0] mq [$];
  int          mcnt = 0;
  int          checks = 0;
  int          errors = 0;

  wire [42:0] dut_vec = {out_op, out_funct, out_shamt, out_idata, out_rd, out_rs1, out_rs2,
                         out_pc, out_is_mem, out_is_ctrl, out_illegal};
  wire [26:0] dut_fld = {out_op, out_funct, out_shamt, out_idata, out_rd, out_rs1, out_rs2,
                         out_is_mem, out_is_ctrl, out_illegal};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Field extraction written straight from the instruction format table.
  function automatic logic [42:0] ref_decode(input logic [15:0] inst, input logic [15:0] pc);
    int op, fn, rd, rs1, rs2, sh, imm, mem, ctrl, ill;
    op  = (inst >> 14) & 3;
    rd  = 0; rs1 = 0; rs2 = 0; sh = 0; imm = 0; mem = 0; ctrl = 0; ill = 0;
    if (op == 0) begin
      rd  = (inst >> 11) & 7;
      rs1 = (inst >> 8) & 7;
      rs2 = (inst >> 5) & 7;
      fn  = (inst >> 2) & 7;
      sh  = inst & 3;
      ill = (fn > 6) ? 1 : 0;
    end else if (op == 1) begin
      fn  = (inst >> 11) & 7;
      rd  = (inst >> 8) & 7;
      rs1 = rd;
      imm = inst & 255;
      ill = (fn > 5) ? 1 : 0;
      mem = (fn == 4 || fn == 5) ? 1 : 0;
    end else begin
      fn   = (inst >> 11) & 7;
      rs1  = (inst >> 8) & 7;
      imm  = inst & 255;
      ctrl = 1;
    end
    return {2'(op), 3'(fn), 2'(sh), 8'(imm), 3'(rd), 3'(rs1), 3'(rs2), pc,
            1'(mem), 1'(ctrl), 1'(ill)};
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic cycle();
    bit          rdy, enq, deq;
    logic [42:0] nv;
    rdy = (mq.size() < 2);
    deq = (mq.size() != 0) && out_ready;
    enq = in_valid && rdy && !flush;
    nv  = ref_decode(in_inst, in_pc);
    @(posedge clk);
    if (deq && mq[0][0] && mcnt < 255) mcnt++;
    if (flush) begin
      mq.delete();
    end else begin
      if (deq) void'(mq.pop_front());
      if (enq) mq.push_back(nv);
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("illegal_cnt", 64'(illegal_cnt), 64'(mcnt));
    if (mq.size() != 0) chk("head_fields", 64'(dut_vec), 64'(mq[0]));
  endtask

  initial begin
    logic [15:0] pc_a, pc_b, pc_c;
    int          cnt_before;

    //            inst      op    fn    sh    imm     rd    rs1   rs2   mem   ctl   ill
    tbl[0] = '{16'h0A3D, 2'd0, 3'd7, 2'd1, 8'h00, 3'd1, 3'd2, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{16'h4612, 2'd1, 3'd0, 2'd0, 8'h12, 3'd6, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{16'h6B55, 2'd1, 3'd5, 2'd0, 8'h55, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{16'h62F0, 2'd1, 3'd4, 2'd0, 8'hF0, 3'd2, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{16'h7101, 2'd1, 3'd6, 2'd0, 8'h01, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{16'h9D80, 2'd2, 3'd3, 2'd0, 8'h80, 3'd0, 3'd5, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{16'hFFFF, 2'd3, 3'd7, 2'd0, 8'hFF, 3'd0, 3'd7, 3'd0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{16'h387A, 2'd0, 3'd6, 2'd2, 8'h00, 3'd7, 3'd0, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{16'h1C00, 2'd0, 3'd0, 2'd0, 8'h00, 3'd3, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{16'h001C, 2'd0, 3'd7, 2'd0, 8'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};

    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(illegal_cnt), 64'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid_rel", 64'(out_valid), 64'd0);

    // Decode table, streamed back-to-back with out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_inst = tbl[i].inst;
      in_pc   = 16'h0100 + 16'(i);
      cycle();
      chk($sformatf("tbl%0d_fields", i), 64'(dut_fld), 64'(tbl[i][26:0]));
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // Backpressure and order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    pc_a = 16'h0A00; pc_b = 16'h0B00; pc_c = 16'h0C00;
    in_inst = 16'h4612; in_pc = pc_a; cycle();
    in_inst = 16'h0A3D; in_pc = pc_b; cycle();
    in_inst = 16'h9D80; in_pc = pc_c; cycle();
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    cycle();
    cycle();
    chk("bp_head_a", 64'(out_pc), 64'(pc_a));
    out_ready = 1'b1;
    cycle();
    chk("bp_head_b", 64'(out_pc), 64'(pc_b));
    cycle();
    chk("bp_head_c", 64'(out_pc), 64'(pc_c));
    in_valid = 1'b0;
    cycle();
    chk("bp_drained", 64'(out_valid), 64'd0);
    cycle();

    // Flush colliding with an enqueue and a dequeue of an illegal head
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst = 16'h001C; in_pc = 16'h0300; cycle();
    in_inst = 16'h4612; in_pc = 16'h0301; cycle();
    cnt_before = int'(illegal_cnt);
    flush = 1'b1; out_ready = 1'b1;
    in_inst = 16'h9D80; in_pc = 16'h03DD;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_cnt_head", 64'(illegal_cnt), 64'(cnt_before + 1));
    for (int i = 0; i < 3; i++) cycle();

    // Counter saturation
    in_valid = 1'b1;
    in_inst  = 16'h001C;
    for (int i = 0; i < 300; i++) begin
      in_pc = 16'(i);
      cycle();
    end
    chk("sat_255", 64'(illegal_cnt), 64'd255);
    in_valid = 1'b0;
    cycle();

    // Asynchronous reset while two entries are queued
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst = 16'h001C; in_pc = 16'h0500; cycle();
    in_inst = 16'h4612; in_pc = 16'h0501; cycle();
    in_valid = 1'b0;
    chk("ar_pre_full", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_cnt", 64'(illegal_cnt), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    mq.delete();
    mcnt = 0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; out_ready = 1'b1;
    in_inst = 16'h6B55; in_pc = 16'h0600;
    cycle();
    chk("ar_latency", 64'(out_valid), 64'd1);
    chk("ar_latency_pc", 64'(out_pc), 64'h0600);
    in_valid = 1'b0;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_inst   = 16'($urandom);
      in_pc     = 16'($urandom);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
